// File: rtl/dm_cache_ctrl_if.sv
// Bus bundle between the cache controller, its CPU, its tag/data arrays and main memory.
// master = controller side, slave = environment (CPU, arrays, memory).
interface dm_cache_ctrl_if;
    logic         cpu_req_valid_i;
    logic         cpu_req_rw_i;
    logic [31:0]  cpu_req_addr_i;
    logic [31:0]  cpu_req_data_i;
    logic         cpu_res_ready_o;
    logic [31:0]  cpu_res_data_o;
    logic [9:0]   tag_req_index_o;
    logic         tag_req_we_o;
    logic [19:0]  tag_write_o;
    logic [19:0]  tag_read_i;
    logic [9:0]   data_req_index_o;
    logic         data_req_we_o;
    logic [127:0] data_write_o;
    logic [127:0] data_read_i;
    logic         mem_req_valid_o;
    logic         mem_req_rw_o;
    logic [31:0]  mem_req_addr_o;
    logic [127:0] mem_req_data_o;
    logic         mem_data_ready_i;
    logic [127:0] mem_data_i;

    modport master (
        input  cpu_req_valid_i, cpu_req_rw_i, cpu_req_addr_i, cpu_req_data_i,
        output cpu_res_ready_o, cpu_res_data_o,
        output tag_req_index_o, tag_req_we_o, tag_write_o,
        input  tag_read_i,
        output data_req_index_o, data_req_we_o, data_write_o,
        input  data_read_i,
        output mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o,
        input  mem_data_ready_i, mem_data_i
    );

    modport slave (
        output cpu_req_valid_i, cpu_req_rw_i, cpu_req_addr_i, cpu_req_data_i,
        input  cpu_res_ready_o, cpu_res_data_o,
        input  tag_req_index_o, tag_req_we_o, tag_write_o,
        output tag_read_i,
        input  data_req_index_o, data_req_we_o, data_write_o,
        output data_read_i,
        input  mem_req_valid_o, mem_req_rw_o, mem_req_addr_o, mem_req_data_o,
        output mem_data_ready_i, mem_data_i
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Write-back, write-allocate controller for a 1024-line direct-mapped cache (128-bit lines).
// Optional hit/miss counters enabled by defining DM_CACHE_STATS_EN.
module dm_cache_ctrl (
    input  logic               clk_i,
    input  logic               rst_ni,
    dm_cache_ctrl_if.master    bus,
    output logic [31:0]        hit_cnt_o,
    output logic [31:0]        miss_cnt_o
);
    typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_e;

    state_e        state_q, state_d;
    logic          rw_q, rw_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [127:0]  mem_data_q, mem_data_d;
    logic          first_q, first_d;
    logic          hit;
    logic          count_hit, count_miss;
    logic [6:0]    word_lsb;
    logic [127:0]  merged_line;

    assign hit      = bus.tag_read_i[19] && (bus.tag_read_i[17:0] == addr_q[31:14]);
    assign word_lsb = {addr_q[3:2], 5'd0};

    assign bus.tag_req_index_o  = addr_q[13:4];
    assign bus.data_req_index_o = addr_q[13:4];
    assign bus.mem_req_valid_o  = (state_q == WRITE_BACK) || (state_q == ALLOCATE);
    assign bus.mem_req_rw_o     = (state_q == WRITE_BACK);
    assign bus.mem_req_addr_o   = mem_addr_q;
    assign bus.mem_req_data_o   = mem_data_q;

    always_comb begin
        merged_line = bus.data_read_i;
        merged_line[word_lsb +: 32] = wdata_q;
    end

    // Array and CPU strobes are combinational in COMPARE/ALLOCATE so a hit answers one cycle after IDLE.
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        first_d    = first_q;
        count_hit  = 1'b0;
        count_miss = 1'b0;
        bus.cpu_res_ready_o = 1'b0;
        bus.cpu_res_data_o  = '0;
        bus.tag_req_we_o    = 1'b0;
        bus.tag_write_o     = '0;
        bus.data_req_we_o   = 1'b0;
        bus.data_write_o    = '0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req_valid_i) begin
                    rw_d    = bus.cpu_req_rw_i;
                    addr_d  = bus.cpu_req_addr_i;
                    wdata_d = bus.cpu_req_data_i;
                    first_d = 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                first_d    = 1'b0;
                count_hit  = first_q && hit;
                count_miss = first_q && !hit;
                if (hit) begin
                    bus.cpu_res_ready_o = 1'b1;
                    if (rw_q) begin
                        bus.data_req_we_o = 1'b1;
                        bus.data_write_o  = merged_line;
                        bus.tag_req_we_o  = 1'b1;
                        bus.tag_write_o   = {2'b11, addr_q[31:14]};
                    end else begin
                        bus.cpu_res_data_o = bus.data_read_i[word_lsb +: 32];
                    end
                    state_d = IDLE;
                end else if (bus.tag_read_i[19] && bus.tag_read_i[18]) begin
                    mem_addr_d = {bus.tag_read_i[17:0], addr_q[13:4], 4'h0};
                    mem_data_d = bus.data_read_i;
                    state_d    = WRITE_BACK;
                end else begin
                    mem_addr_d = {addr_q[31:4], 4'h0};
                    state_d    = ALLOCATE;
                end
            end
            WRITE_BACK: begin
                if (bus.mem_data_ready_i) begin
                    mem_addr_d = {addr_q[31:4], 4'h0};
                    state_d    = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (bus.mem_data_ready_i) begin
                    bus.data_req_we_o = 1'b1;
                    bus.data_write_o  = bus.mem_data_i;
                    bus.tag_req_we_o  = 1'b1;
                    bus.tag_write_o   = {2'b10, addr_q[31:14]};
                    state_d           = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            first_q    <= first_d;
        end
    end

`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'd0, count_hit};
        miss_cnt_d = miss_cnt_q + {31'd0, count_miss};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = count_hit ^ count_miss;
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: models the tag/data arrays and drives memory responses by hand.
module tb_dm_cache_ctrl;
    logic        clk;
    logic        rst_n;
    logic        clr;
    logic [31:0] hit_cnt, miss_cnt;
    int unsigned tests;
    int unsigned fails;

    logic [19:0]  tag_mem  [1024];
    logic [127:0] data_mem [1024];

    localparam logic [127:0] L1 = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] L2 = 128'h33333333_DEADBEEF_11111111_00000000;
    localparam logic [127:0] L3 = 128'h77777777_66666666_55555555_44444444;
    localparam logic [127:0] L4 = 128'hBBBBBBBB_AAAAAAAA_99999999_88888888;
    localparam logic [127:0] L5 = 128'hFFFFFFFF_EEEEEEEE_CCCCCCCC_12345678;

    dm_cache_ctrl_if bus ();

    dm_cache_ctrl dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus.master),
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.tag_read_i  = tag_mem[bus.tag_req_index_o];
    assign bus.data_read_i = data_mem[bus.data_req_index_o];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            if (bus.tag_req_we_o)  tag_mem[bus.tag_req_index_o]   <= bus.tag_write_o;
            if (bus.data_req_we_o) data_mem[bus.data_req_index_o] <= bus.data_write_o;
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Presents a request for one IDLE cycle; returns sampled in the COMPARE cycle.
    task automatic issue(input logic rw, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cpu_req_valid_i = 1'b1;
        bus.cpu_req_rw_i    = rw;
        bus.cpu_req_addr_i  = a;
        bus.cpu_req_data_i  = d;
        @(negedge clk);
        bus.cpu_req_valid_i = 1'b0;
        bus.cpu_req_rw_i    = 1'b0;
        #1;
    endtask

    task automatic mem_respond(input logic [127:0] line);
        bus.mem_data_ready_i = 1'b1;
        bus.mem_data_i       = line;
        #1;
    endtask

    task automatic mem_release();
        @(negedge clk);
        bus.mem_data_ready_i = 1'b0;
        bus.mem_data_i       = '0;
        #1;
    endtask

    task automatic check_counts(input string tag, input logic [31:0] h, input logic [31:0] m);
`ifdef DM_CACHE_STATS_EN
        check({tag, "_hit"}, hit_cnt, h);
        check({tag, "_miss"}, miss_cnt, m);
`else
        check({tag, "_hit"}, hit_cnt, 32'h0);
        check({tag, "_miss"}, miss_cnt, 32'h0);
        if (h == m) tests += 0;
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        clr   = 1'b1;
        bus.cpu_req_valid_i  = 1'b0;
        bus.cpu_req_rw_i     = 1'b0;
        bus.cpu_req_addr_i   = '0;
        bus.cpu_req_data_i   = '0;
        bus.mem_data_ready_i = 1'b0;
        bus.mem_data_i       = '0;
        repeat (3) step();
        check("rst_ready", bus.cpu_res_ready_o, 1'b0);
        check("rst_mem_valid", bus.mem_req_valid_o, 1'b0);
        check("rst_we", {bus.tag_req_we_o, bus.data_req_we_o}, 2'b00);
        check("rst_index", bus.tag_req_index_o, 10'h0);
        check("rst_mem_addr", bus.mem_req_addr_o, 32'h0);
        check_counts("rst_cnt", 32'd0, 32'd0);
        clr   = 1'b0;
        rst_n = 1'b1;

        // Read miss on an invalid victim: fill then hit
        issue(1'b0, 32'h0000_1004, 32'h0);
        check("s1_cmp_ready", bus.cpu_res_ready_o, 1'b0);
        check("s1_index", bus.data_req_index_o, 10'h100);
        step();
        check("s1_alloc_valid", {bus.mem_req_valid_o, bus.mem_req_rw_o}, 2'b10);
        check("s1_alloc_addr", bus.mem_req_addr_o, 32'h0000_1000);
        mem_respond(L1);
        check("s1_data_we", bus.data_req_we_o, 1'b1);
        check("s1_data_wr", bus.data_write_o, L1);
        check("s1_tag_we", bus.tag_req_we_o, 1'b1);
        check("s1_tag_wr", bus.tag_write_o, 20'h80000);
        mem_release();
        check("s1_res_ready", bus.cpu_res_ready_o, 1'b1);
        check("s1_res_data", bus.cpu_res_data_o, 32'h1111_1111);
        check("s1_relookup_we", {bus.tag_req_we_o, bus.data_req_we_o}, 2'b00);
        step();
        check("s1_idle_ready", bus.cpu_res_ready_o, 1'b0);
        check("s1_idle_data", bus.cpu_res_data_o, 32'h0);

        // Write hit
        issue(1'b1, 32'h0000_1008, 32'hDEAD_BEEF);
        check("s2_ready", bus.cpu_res_ready_o, 1'b1);
        check("s2_data_we", bus.data_req_we_o, 1'b1);
        check("s2_data_wr", bus.data_write_o, L2);
        check("s2_tag_wr", {bus.tag_req_we_o, bus.tag_write_o}, {1'b1, 20'hC0000});
        check("s2_no_mem", bus.mem_req_valid_o, 1'b0);
        step();
        check("s2_we_drop", {bus.tag_req_we_o, bus.data_req_we_o, bus.cpu_res_ready_o}, 3'b000);

        // Read miss on a dirty victim: write-back, fill, hit
        issue(1'b0, 32'h0000_5004, 32'h0);
        check("s3_cmp_ready", bus.cpu_res_ready_o, 1'b0);
        step();
        check("s3_wb_valid", {bus.mem_req_valid_o, bus.mem_req_rw_o}, 2'b11);
        check("s3_wb_addr", bus.mem_req_addr_o, 32'h0000_1000);
        check("s3_wb_data", bus.mem_req_data_o, L2);
        step();
        check("s3_wb_hold_addr", bus.mem_req_addr_o, 32'h0000_1000);
        check("s3_wb_hold_we", {bus.tag_req_we_o, bus.data_req_we_o}, 2'b00);
        mem_respond('0);
        check("s3_wb_ack_we", {bus.tag_req_we_o, bus.data_req_we_o}, 2'b00);
        mem_release();
        check("s3_alloc_valid", {bus.mem_req_valid_o, bus.mem_req_rw_o}, 2'b10);
        check("s3_alloc_addr", bus.mem_req_addr_o, 32'h0000_5000);
        mem_respond(L3);
        check("s3_tag_wr", bus.tag_write_o, 20'h80001);
        mem_release();
        check("s3_res", {bus.cpu_res_ready_o, bus.cpu_res_data_o}, {1'b1, 32'h5555_5555});
        step();
        check_counts("s3_cnt", 32'd1, 32'd2);

        // Clean miss with memory stalling 5 cycles: latency k+3
        issue(1'b0, 32'h0000_9004, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("s4_stall_req", {bus.mem_req_valid_o, bus.mem_req_rw_o, bus.mem_req_addr_o},
                  {2'b10, 32'h0000_9000});
            check("s4_stall_quiet", {bus.cpu_res_ready_o, bus.tag_req_we_o, bus.data_req_we_o}, 3'b000);
        end
        step();
        mem_respond(L4);
        check("s4_fill_we", {bus.tag_req_we_o, bus.data_req_we_o}, 2'b11);
        mem_release();
        check("s4_res", {bus.cpu_res_ready_o, bus.cpu_res_data_o}, {1'b1, 32'h9999_9999});

        // Async reset in the middle of ALLOCATE
        issue(1'b0, 32'h0000_D004, 32'h0);
        step();
        check("s5_alloc_valid", bus.mem_req_valid_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_valid", bus.mem_req_valid_o, 1'b0);
        check("s5_rst_we", {bus.tag_req_we_o, bus.data_req_we_o}, 2'b00);
        check("s5_rst_addr", bus.mem_req_addr_o, 32'h0);
        step();
        rst_n = 1'b1;
        check_counts("s5_rst_cnt", 32'd0, 32'd0);
        issue(1'b0, 32'h0000_1004, 32'h0);
        check("s5_cmp_ready", bus.cpu_res_ready_o, 1'b0);
        step();
        check("s5_alloc_addr", {bus.mem_req_valid_o, bus.mem_req_rw_o, bus.mem_req_addr_o},
              {2'b10, 32'h0000_1000});
        mem_respond(L5);
        mem_release();
        check("s5_res", {bus.cpu_res_ready_o, bus.cpu_res_data_o}, {1'b1, 32'hCCCC_CCCC});
        step();
        check_counts("s5_cnt", 32'd0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
